// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: nPCSel codes, reset/bubble encodings, fetch FSM states, IF/ID layout.
package fetch_stage_pkg;

  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_BNE = 3'b100;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_WAIT_SLOT = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Branch/jump resolution for the ID instruction: raw take condition and 32-bit target.
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [25:0] imm26,
  input  logic [31:0] pc4,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        take,
  output logic [31:0] target
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign br_tgt = pc4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign j_tgt  = {pc4[31:28], imm26, 2'b00};

  // Unused codes 101..111 fall through to sequential and are never taken.
  always_comb begin
    take   = 1'b0;
    target = pc4;
    case (sel)
      NPC_BEQ: begin take = (rs_val == rt_val); target = br_tgt; end
      NPC_BNE: begin take = (rs_val != rt_val); target = br_tgt; end
      NPC_J:   begin take = 1'b1;               target = j_tgt;  end
      NPC_JR:  begin take = 1'b1;               target = rs_val; end
      default: begin take = 1'b0;               target = pc4;    end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// PC + IF/ID register with ID-stage branch resolution. Delay slot by default;
// define FETCH_BRANCH_SQUASH_EN to squash the in-flight fetch on a taken transfer instead.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  id_npc_sel,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        redirect
);

  logic [31:0] pc;
  logic [31:0] pc4_f;
  if_id_t      if_id;
  if_id_t      fetched;
  if_id_t      bubble;
  logic        br_take;
  logic [31:0] br_tgt;
  logic        taken;

  npc_calc u_npc (
    .sel    (id_npc_sel),
    .imm26  (if_id.instr[25:0]),
    .pc4    (if_id.pc4),
    .rs_val (id_rs_val),
    .rt_val (id_rt_val),
    .take   (br_take),
    .target (br_tgt)
  );

  assign pc4_f   = pc + 32'd4;
  assign fetched = {imem_rdata, pc4_f, 1'b1};
  assign bubble  = {NOP_INSTR, 32'h0, 1'b0};
  assign taken   = if_id.valid & ~stall & br_take;

  assign imem_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;
  assign redirect    = taken;

`ifdef FETCH_BRANCH_SQUASH_EN
  // A taken transfer kills whatever fetch is at pc, ready or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= {NOP_INSTR, 32'h0, 1'b0};
    end else if (!stall) begin
      if (taken) begin
        if_id <= bubble;
        pc    <= br_tgt;
      end else if (imem_ready) begin
        if_id <= fetched;
        pc    <= pc4_f;
      end else begin
        if_id <= bubble;
      end
    end
  end
`else
  logic [0:0]  state;
  logic [31:0] pend_tgt;

  // A taken transfer with the slot fetch still outstanding parks the target
  // until the slot instruction arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_id    <= {NOP_INSTR, 32'h0, 1'b0};
      state    <= ST_RUN;
      pend_tgt <= 32'h0;
    end else if (!stall) begin
      if (state == ST_RUN) begin
        if (imem_ready) begin
          if_id <= fetched;
          pc    <= taken ? br_tgt : pc4_f;
        end else begin
          if_id <= bubble;
          if (taken) begin
            pend_tgt <= br_tgt;
            state    <= ST_WAIT_SLOT;
          end
        end
      end else begin
        if (imem_ready) begin
          if_id <= fetched;
          pc    <= pend_tgt;
          state <= ST_RUN;
        end else begin
          if_id <= bubble;
        end
      end
    end
  end
`endif

endmodule
